// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared fetch/decode definitions for the RV32 pipeline.
package if_id_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } fetch_pkt_t;
endpackage

// File: rtl/if_id_stage_skid_fifo.sv
// if_id_stage_skid_fifo: small synchronous FIFO with clear; push+pop same cycle allowed.
module if_id_stage_skid_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign w_pop = pop & (r_count != '0);
  assign w_push = push & (r_count != CW'(DEPTH));
  assign head = r_mem[r_rd];
  assign count = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr == PW'(DEPTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == PW'(DEPTH - 1) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with skid FIFO, bubble insertion and perf counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W = 16,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [31:0]                       InstrF,
  input  logic [31:0]                       PCF,
  input  logic [31:0]                       PCPlus4F,
  input  logic                              FetchValid,
  output logic                              FetchReady,
  input  logic                              StallD,
  input  logic                              FlushD,
  output logic [31:0]                       InstrD,
  output logic [31:0]                       PCD,
  output logic [31:0]                       PCPlus4D,
  output logic                              ValidD,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   SkidCount,
  output logic [CNT_W-1:0]                  StallCnt,
  output logic [CNT_W-1:0]                  BubbleCnt
);
  localparam int SW = $clog2(SKID_DEPTH + 1);
  fetch_pkt_t w_fetch, w_head, w_next;
  logic w_acc, w_skid_ne, w_load, w_bubble, w_stall_inc;
  assign w_fetch = '{instr: InstrF, pc: PCF, pcplus4: PCPlus4F};
  assign FetchReady = ~reset & (SkidCount < SW'(SKID_DEPTH));
  assign w_acc = FetchValid & FetchReady;
  assign w_skid_ne = SkidCount != '0;
  assign w_load = FlushD | ~StallD;
  assign w_bubble = FlushD | (~w_skid_ne & ~w_acc);
  assign w_next = w_skid_ne ? w_head : w_fetch;
  assign w_stall_inc = ~FlushD & StallD & ValidD;
  // Fetch enters the skid only when it cannot go straight to decode.
  if_id_stage_skid_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(SKID_DEPTH)) u_skid (
    .clk  (clk),
    .clr  (reset | FlushD),
    .push (w_acc & ~FlushD & (StallD | w_skid_ne)),
    .pop  (~FlushD & ~StallD),
    .din  (w_fetch),
    .head (w_head),
    .count(SkidCount)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD <= NOP_INSTR;
      PCD <= '0;
      PCPlus4D <= '0;
      ValidD <= 1'b0;
      StallCnt <= '0;
      BubbleCnt <= '0;
    end else begin
      if (w_load) {InstrD, PCD, PCPlus4D, ValidD} <= w_bubble ? {NOP_INSTR, 64'b0, 1'b0} : {w_next, 1'b1};
      StallCnt <= StallCnt + CNT_W'(w_stall_inc & ~&StallCnt);
      BubbleCnt <= BubbleCnt + CNT_W'(w_load & w_bubble & ~&BubbleCnt);
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed stimulus with a program-order scoreboard for if_id_stage.
module tb_if_id_stage;
  import if_id_stage_pkg::*;
  logic clk = 0, reset = 1;
  logic [31:0] InstrF = 0, PCF = 0, PCPlus4F = 4;
  logic FetchValid = 0, StallD = 0, FlushD = 0;
  logic FetchReady, ValidD, s_ready, s_valid;
  logic [31:0] InstrD, PCD, PCPlus4D, s_instr, s_pc, s_pc4;
  logic [1:0] SkidCount, s_skid;
  logic [15:0] StallCnt, BubbleCnt;
  logic [3:0] s_stall, s_bubble;
  int checks = 0, errors = 0;
  fetch_pkt_t q[$];

  if_id_stage dut (
    .clk(clk), .reset(reset), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .FetchValid(FetchValid), .FetchReady(FetchReady), .StallD(StallD), .FlushD(FlushD),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .SkidCount(SkidCount), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
  );

  if_id_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .FetchValid(FetchValid), .FetchReady(s_ready), .StallD(StallD), .FlushD(FlushD),
    .InstrD(s_instr), .PCD(s_pc), .PCPlus4D(s_pc4), .ValidD(s_valid),
    .SkidCount(s_skid), .StallCnt(s_stall), .BubbleCnt(s_bubble)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc);
    FetchValid = v;
    PCF = pc;
    PCPlus4F = pc + 32'd4;
    InstrF = 32'hA000_0000 | pc;
  endtask

  // One clock; the scoreboard tracks accepted words not yet in decode.
  task automatic tick();
    logic acc, rs, fl, st;
    fetch_pkt_t p, e;
    #1;
    acc = FetchValid & FetchReady;
    rs = reset;
    fl = FlushD;
    st = StallD;
    p = '{instr: InstrF, pc: PCF, pcplus4: PCPlus4F};
    @(posedge clk);
    #1;
    if (rs | fl) q.delete();
    else begin
      if (acc) q.push_back(p);
      if (!st) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_decode", 128'({ValidD, InstrD, PCD, PCPlus4D}), 128'({1'b1, e}));
        end else
          check("sb_bubble", 128'({ValidD, InstrD, PCD, PCPlus4D}), 128'({1'b0, 32'h13, 64'b0}));
      end
    end
    check("sb_skid", 128'(SkidCount), 128'(q.size()));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_instr"}, 128'(InstrD), 128'(32'h13));
    check({tag, "_pc"}, 128'({PCD, PCPlus4D}), 128'(0));
    check({tag, "_valid"}, 128'(ValidD), 128'(0));
    check({tag, "_skid"}, 128'(SkidCount), 128'(0));
    check({tag, "_cnts"}, 128'({StallCnt, BubbleCnt}), 128'(0));
    check({tag, "_ready"}, 128'(FetchReady), 128'(0));
  endtask

  initial begin
    // reset and zero-bubble fetch path
    tick();
    check_reset("rst");
    reset = 0;
    #1 check("ready_after_rst", 128'(FetchReady), 128'(1));
    fetch(1, 32'h0); tick();
    check("t1_pc0", 128'({ValidD, PCD}), 128'({1'b1, 32'h0}));
    fetch(1, 32'h4); tick();
    check("t1_pc4", 128'(PCD), 128'(32'h4));
    fetch(1, 32'h8); tick();
    check("t1_pc8", 128'({ValidD, PCD, SkidCount}), 128'({1'b1, 32'h8, 2'd0}));
    // stall fills skid, drains in order
    fetch(1, 32'hC); tick();
    fetch(1, 32'h10); tick();
    check("t2_hold", 128'(PCD), 128'(32'h10));
    StallD = 1;
    fetch(1, 32'h14); tick();
    fetch(1, 32'h18); tick();
    check("t2_skid2", 128'(SkidCount), 128'(2));
    fetch(1, 32'h1C);
    #1 check("t2_ready0", 128'(FetchReady), 128'(0));
    tick();
    check("t2_held", 128'({PCD, StallCnt}), 128'({32'h10, 16'd3}));
    StallD = 0; tick();
    check("t2_pop14", 128'(PCD), 128'(32'h14));
    tick();
    check("t2_pop18", 128'(PCD), 128'(32'h18));
    fetch(1, 32'h20); tick();
    check("t2_new", 128'({PCD, StallCnt, BubbleCnt}), 128'({32'h1C, 16'd3, 16'd0}));
    // flush with a full skid
    StallD = 1;
    fetch(1, 32'h24); tick();
    check("t3_skid2", 128'(SkidCount), 128'(2));
    FlushD = 1;
    fetch(1, 32'h28); tick();
    check("t3_flush", 128'({InstrD, ValidD, SkidCount}), 128'({32'h13, 1'b0, 2'd0}));
    check("t3_cnts", 128'({StallCnt, BubbleCnt}), 128'({16'd4, 16'd1}));
    // starvation bubbles
    FlushD = 0; StallD = 0;
    fetch(0, 32'h2C);
    repeat (4) begin
      tick();
      check("t4_bubble", 128'({InstrD, ValidD}), 128'({32'h13, 1'b0}));
    end
    check("t4_bcnt", 128'(BubbleCnt), 128'(5));
    // reset mid-stall with one skid entry
    fetch(1, 32'h40); tick();
    StallD = 1;
    fetch(1, 32'h44); tick();
    check("t5_skid1", 128'({SkidCount, StallCnt}), 128'({2'd1, 16'd5}));
    reset = 1; tick();
    check_reset("t5");
    reset = 0; StallD = 0;
    // counter saturation on the CNT_W=4 instance
    fetch(1, 32'h60); tick();
    StallD = 1;
    fetch(0, 32'h64);
    repeat (14) tick();
    check("t6_e", 128'({s_stall, StallCnt}), 128'({4'hE, 16'd14}));
    tick();
    check("t6_f", 128'(s_stall), 128'(4'hF));
    repeat (5) tick();
    check("t6_sat", 128'({s_stall, StallCnt}), 128'({4'hF, 16'd20}));
    // flush drops an accepted fetch
    StallD = 0; FlushD = 1;
    fetch(1, 32'h80); tick();
    FlushD = 0;
    fetch(0, 32'h84); tick();
    check("t7_dropped", 128'({ValidD, SkidCount, BubbleCnt}), 128'({1'b0, 2'd0, 16'd2}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
